seq_shift_add_multiplier: RTL and testbench
===========================================

// Module: seq_shift_add_multiplier
// PURPOSE
//  Iterative radix-2 shift-add multiplier, parametrised in WIDTH.
//  Supports unsigned and sign-magnitude operands, selected per operation.
//  One partial product per clock behind a valid/ready handshake on both sides.
//  Successor to the combinational array multiplier in the arithmetic chip.
// PARAMETERS
//  WIDTH  32  operand width in bits (>=4); result is 2*WIDTH bits
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands/mode present
//  in_ready   out  1        block can accept (high only in IDLE)
//  a          in   WIDTH    multiplicand
//  b          in   WIDTH    multiplier
//  sm_mode    in   1        1: sign-magnitude (MSB=sign), 0: unsigned
//  out_valid  out  1        result valid, held until accepted
//  out_ready  in   1        consumer accepts result
//  result     out  2*WIDTH  product
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, result=0, internal regs=0.
//  - Reset mid-operation aborts the current product; it produces no result.
//  - States:
//      IDLE: in_ready=1; in_valid&&in_ready at edge E0 latches operands,
//            clears accumulator and counter, and moves to CALC.
//      CALC: one iteration per edge; if mplr[0], acc+=mcand; mcand<<=1;
//            mplr>>=1; cnt++. After the WIDTH-th iteration (edge E_WIDTH),
//            result is loaded, out_valid=1 and state moves to DONE.
//      DONE: result held stable while out_valid && !out_ready.
//            out_valid && out_ready at an edge -> IDLE, out_valid=0.
//  - Latency: out_valid first high WIDTH edges after the accept edge.
//    Throughput: one product per WIDTH+2 cycles with out_ready tied high.
//  - in_ready=0 in CALC and DONE; in_valid is ignored there (no queueing).
//  - result is updated only on entry to DONE and retains its old value
//    otherwise.
//  - Unsigned (sm_mode=0): result = a*b, full 2*WIDTH bits, no truncation.
//  - Sign-magnitude (sm_mode=1):
//      magnitudes a[WIDTH-2:0] and b[WIDTH-2:0];
//      result[2*WIDTH-2:0] = |a|*|b|;
//      result[2*WIDTH-1]   = a[MSB]^b[MSB].
//    Bit 2*WIDTH-2 is always 0 in this mode.
//  - Negative zero: in sm_mode, a zero magnitude product forces the sign
//    bit to 0. Inputs of -0 are accepted and treated as 0.
//  - sm_mode is latched at accept; changes during CALC/DONE have no effect.
//  - Counter width is $clog2(WIDTH)+1; no wrap occurs before the
//    terminal count.
// CONFIGURATION
//  SEQ_MUL_EARLY_EXIT_EN defined:
//    - In CALC, if the remaining mplr==0 at an edge, that edge loads result
//      and enters DONE.
//    - Latency = max(1, index of highest set multiplier bit + 1) edges.
//    - A zero multiplier completes in 1 edge.
//  Not defined:
//    - Fixed latency of WIDTH edges for every operand.
//  Result values are identical in both builds.
// TESTING  (WIDTH=8 unless noted)
//  1. Unsigned: a=0xFF, b=0xFF, sm_mode=0
//     -> result=0xFE01, out_valid exactly 8 edges after accept.
//  2. Sign-magnitude: a=0x83 (-3), b=0x05 (+5)
//     -> 0x800F. a=0x83, b=0x85 -> 0x000F.
//  3. Negative zero: a=0x80, b=0x05, sm_mode=1 -> result=0x0000.
//  4. Backpressure: out_ready=0 for 5 cycles, new in_valid during DONE
//     -> result/out_valid stable, in_ready=0, the second operand is not
//     taken until IDLE.
//  5. Reset at CALC cycle 4 -> next cycle out_valid=0, in_ready=1;
//     a following a=3, b=7 gives 0x0015.
//  6. EARLY_EXIT on: b=0x01 -> 1-edge latency; b=0x00 -> 1 edge, 0x0000.
//     EARLY_EXIT off: both take 8 edges.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier (unsigned or sign-magnitude per operation).
// Define SEQ_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sm_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg, acc_reg, result_reg;
  logic [2*WIDTH-1:0]   acc_next, final_value;
  logic [WIDTH-1:0]     mplr_reg, mplr_next;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [CW-1:0]        cnt_reg;
  logic                 sm_reg, sign_reg;
  logic                 accept, last_iter;

  // In sign-magnitude mode the MSB is a sign, so it is stripped from the operands.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_mag
      assign a_mag[gi] = a[gi];
      assign b_mag[gi] = b[gi];
    end
  endgenerate
  assign a_mag[WIDTH-1] = a[WIDTH-1] & ~sm_mode;
  assign b_mag[WIDTH-1] = b[WIDTH-1] & ~sm_mode;

  assign accept    = in_valid && (state_reg == IDLE);
  assign acc_next  = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
  assign mplr_next = mplr_reg >> 1;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign last_iter = (cnt_reg == CW'(WIDTH - 1)) || (mplr_next == '0);
`else
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));
`endif

  // A zero magnitude never carries a sign, so -0 results collapse to +0.
  assign final_value = sm_reg ? {sign_reg && (acc_next != '0), acc_next[2*WIDTH-2:0]}
                              : acc_next;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    result    = result_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplr_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sm_reg     <= 1'b0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mcand_reg <= {{WIDTH{1'b0}}, a_mag};
            mplr_reg  <= b_mag;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sm_reg    <= sm_mode;
            sign_reg  <= sm_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_next;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_iter) result_reg <= final_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier at WIDTH=8; honours SEQ_MUL_EARLY_EXIT_EN.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          sm_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
  } exp_t;
  exp_t q[$];

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sm_mode(sm_mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sm);
    logic [2*W-1:0] m;
    if (!sm) return {8'h00, x} * {8'h00, y};
    m = {9'h000, x[6:0]} * {9'h000, y[6:0]};
    return {(x[7] ^ y[7]) && (m != 0), m[14:0]};
  endfunction

  function automatic int model_lat(input logic [W-1:0] y, input logic sm);
    logic [W-1:0] e;
    int l;
    e = sm ? {1'b0, y[6:0]} : y;
    l = 1;
    for (int i = 0; i < W; i++) if (e[i]) l = i + 1;
`ifndef SEQ_MUL_EARLY_EXIT_EN
    l = W;
`endif
    return l;
  endfunction

  // Called at the negedge after the accept edge; counts edges until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid got 0 want 1 within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                        input logic [2*W-1:0] want, input string tag);
    exp_t e;
    int lat;
    @(negedge clk);
    a = x; b = y; sm_mode = sm; in_valid = 1'b1;
    e.res = want; e.lat = model_lat(y, sm);
    q.push_back(e);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after accept: they must have been latched.
    in_valid = 1'b0; sm_mode = ~sm; a = W'($urandom); b = W'($urandom);
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (lat != e.lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat);
    end
    checks++;
    if (result !== e.res) begin
      errors++; $display("FAIL %s result: got %h want %h", tag, result, e.res);
    end
    $display("op %s a=%h b=%h sm=%b result=%h latency=%0d", tag, x, y, sm, result, lat);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s handshake: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
    end
    checks++;
    if (result !== e.res) begin
      errors++; $display("FAIL %s result_hold: got %h want %h", tag, result, e.res);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: result=%h out_valid=%b in_ready=%b want 0000/0/1", result, out_valid, in_ready);
    end
    $display("reset result=%h out_valid=%b in_ready=%b", result, out_valid, in_ready);
  endtask

  task automatic test_unsigned;
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uns_ff_ff");
    run_op(8'h00, 8'hFF, 1'b0, 16'h0000, "uns_00_ff");
    run_op(8'hFF, 8'h01, 1'b0, 16'h00FF, "uns_ff_01");
    run_op(8'h12, 8'h34, 1'b0, 16'h03A8, "uns_12_34");
    run_op(8'h80, 8'h80, 1'b0, 16'h4000, "uns_80_80");
  endtask

  task automatic test_sign_magnitude;
    run_op(8'h83, 8'h05, 1'b1, 16'h800F, "sm_m3_p5");
    run_op(8'h83, 8'h85, 1'b1, 16'h000F, "sm_m3_m5");
    run_op(8'hFF, 8'hFF, 1'b1, 16'h3F01, "sm_max_max");
    run_op(8'h7F, 8'hFF, 1'b1, 16'hBF01, "sm_pmax_nmax");
  endtask

  task automatic test_negative_zero;
    run_op(8'h80, 8'h05, 1'b1, 16'h0000, "nz_a");
    run_op(8'h05, 8'h80, 1'b1, 16'h0000, "nz_b");
    run_op(8'h80, 8'h80, 1'b1, 16'h0000, "nz_both");
    run_op(8'h00, 8'h85, 1'b1, 16'h0000, "nz_zero_neg");
  endtask

  task automatic test_backpressure;
    exp_t e;
    int lat;
    @(negedge clk);
    a = 8'h0F; b = 8'h0E; sm_mode = 1'b0; in_valid = 1'b1;
    e.res = 16'h00D2; e.lat = model_lat(8'h0E, 1'b0); q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    // Second operand offered while the first result is stalled.
    a = 8'h05; b = 8'h06; in_valid = 1'b1;
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res) begin
        errors++;
        $display("FAIL bp_stall%0d: out_valid=%b in_ready=%b result=%h want 1/0/%h",
                 i, out_valid, in_ready, result, e.res);
      end
    end
    $display("bp stalled result=%h", result);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    e.res = 16'h001E; e.lat = model_lat(8'h06, 1'b0); q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    e = q.pop_front();
    checks++;
    if (result !== e.res || lat != e.lat) begin
      errors++; $display("FAIL bp_second: result=%h lat=%0d want %h/%0d", result, lat, e.res, e.lat);
    end
    $display("bp second result=%h latency=%0d", result, lat);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc;
    int seen;
    @(negedge clk);
    a = 8'h55; b = 8'hF7; sm_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b result=%h want 0/1/0000", out_valid, in_ready, result);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_abort: out_valid cycles got %0d want 0", seen);
    end
    $display("reset mid-calc aborted, out_valid cycles=%0d", seen);
    run_op(8'h03, 8'h07, 1'b0, 16'h0015, "after_rst");
  endtask

  task automatic test_latency;
    run_op(8'h5A, 8'h01, 1'b0, 16'h005A, "lat_b01");
    run_op(8'h5A, 8'h00, 1'b0, 16'h0000, "lat_b00");
    run_op(8'h03, 8'h80, 1'b0, 16'h0180, "lat_b80");
    run_op(8'h03, 8'h81, 1'b1, 16'h8003, "lat_sm81");
    run_op(8'h03, 8'h10, 1'b0, 16'h0030, "lat_b10");
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic sm;
    for (int i = 0; i < 16; i++) begin
      x = W'($urandom); y = W'($urandom); sm = 1'($urandom);
      run_op(x, y, sm, model_mul(x, y, sm), "rand");
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    exp_t e;
    int n;
    int unsigned t, prev;
    xs = '{8'hC3, 8'h11, 8'hFE, 8'h07};
    ys = '{8'h9D, 8'h04, 8'h02, 8'hFF};
    prev = 0;
    out_ready = 1'b1;
    @(negedge clk);
    a = xs[0]; b = ys[0]; sm_mode = 1'b0; in_valid = 1'b1;
    e.res = model_mul(xs[0], ys[0], 1'b0); e.lat = model_lat(ys[0], 1'b0); q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      t = cyc;
      e = q.pop_front();
      checks++;
      if (result !== e.res || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b%0d result: got %h valid=%b want %h", i, result, out_valid, e.res);
      end
      if (i > 0) begin
        checks++;
        if (t - prev != e.lat + 2) begin
          errors++; $display("FAIL b2b%0d period: got %0d want %0d", i, t - prev, e.lat + 2);
        end
      end
      $display("b2b %0d result=%h cycle=%0d", i, result, t);
      prev = t;
      if (i < 3) begin
        a = xs[i+1]; b = ys[i+1];
        e.res = model_mul(xs[i+1], ys[i+1], 1'b0); e.lat = model_lat(ys[i+1], 1'b0);
        q.push_back(e);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_sign_magnitude();
    test_negative_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_latency();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
